// File: rtl/uart_rx_param.sv
// Parametrised UART receiver. Advances only on sample ticks, majority-votes three
// mid-bit samples and hands each word to a one-deep ready/valid output register
// with parity, framing and break flags plus an overrun pulse.
module uart_rx_param #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Rx_EN,
    input  logic                 RX_sample_ENABLE,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 break_det,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned IW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] MID_LO    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] MID       = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] MID_HI    = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] LAST_TICK = SW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state;
    logic                 rxd_meta, rxd_s;
    logic [SW-1:0]        scnt;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 samp_lo, samp_mid;
    logic [DATA_BITS-1:0] data_sh;
    logic                 par_acc, frm_acc, zero_acc;

    logic voted, vote_tick, stop_last, frm_next, zero_next;

    // Majority of the three mid-bit samples; the third is the live synchronised line.
    always_comb begin
        voted     = (samp_lo & samp_mid) | (samp_lo & rxd_s) | (samp_mid & rxd_s);
        vote_tick = RX_sample_ENABLE && (scnt == MID_HI);
        stop_last = (STOP_BITS == 1) ? 1'b1 : stop_idx;
        frm_next  = frm_acc | ~voted;
        zero_next = zero_acc & ~voted;
        busy      = (state != StIdle);
    end

    // Two-flop synchroniser for the asynchronous serial line, idling high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= RxD;
            rxd_s    <= rxd_meta;
        end
    end

    // Frame FSM plus the output register it fills on frame completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            scnt        <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            samp_lo     <= 1'b1;
            samp_mid    <= 1'b1;
            data_sh     <= '0;
            par_acc     <= 1'b0;
            frm_acc     <= 1'b0;
            zero_acc    <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (data_valid && data_ready) data_valid <= 1'b0;

            if (state != StIdle && !Rx_EN) begin
                // Disabled mid-frame: drop the partial frame silently.
                state <= StIdle;
                scnt  <= '0;
            end else if (RX_sample_ENABLE) begin
                if (scnt == MID_LO) samp_lo <= rxd_s;
                if (scnt == MID) samp_mid <= rxd_s;
                case (state)
                    StIdle: begin
                        if (Rx_EN && !rxd_s) begin
                            state <= StStart;
                            scnt  <= '0;
                        end
                    end
                    StStart: begin
                        if (vote_tick && voted) begin
                            state <= StIdle;
                            scnt  <= '0;
                        end else if (scnt == LAST_TICK) begin
                            state    <= StData;
                            scnt     <= '0;
                            bit_idx  <= '0;
                            par_acc  <= 1'b0;
                            frm_acc  <= 1'b0;
                            zero_acc <= 1'b1;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                    StData: begin
                        if (vote_tick) begin
                            data_sh <= {voted, data_sh[DATA_BITS-1:1]};
                            if (voted) zero_acc <= 1'b0;
                        end
                        if (scnt == LAST_TICK) begin
                            scnt <= '0;
                            if (bit_idx == LAST_BIT) begin
                                state    <= (PARITY_EN != 0) ? StParity : StStop;
                                stop_idx <= 1'b0;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                    StParity: begin
                        if (vote_tick) begin
                            par_acc <= (^data_sh) ^ voted ^ PAR_ODD;
                            if (voted) zero_acc <= 1'b0;
                        end
                        if (scnt == LAST_TICK) begin
                            state <= StStop;
                            scnt  <= '0;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                    StStop: begin
                        if (vote_tick && stop_last) begin
                            // Complete half a bit early to catch the next start edge.
                            state <= StIdle;
                            scnt  <= '0;
                            if (!data_valid || data_ready) begin
                                data_out    <= data_sh;
                                parity_err  <= par_acc;
                                framing_err <= frm_next;
                                break_det   <= zero_next;
                                data_valid  <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end else begin
                            if (vote_tick) begin
                                frm_acc  <= frm_next;
                                zero_acc <= zero_next;
                            end
                            if (scnt == LAST_TICK) begin
                                scnt     <= '0;
                                stop_idx <= 1'b1;
                            end else begin
                                scnt <= scnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= StIdle;
                        scnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default instance plus an odd-parity instance
// sharing the same line and handshake.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Rx_EN = 1'b1;
    logic       RX_sample_ENABLE = 1'b0;
    logic       RxD = 1'b1;
    logic       data_ready = 1'b0;

    logic [7:0] data_out, data_out_o;
    logic       data_valid, parity_err, framing_err, break_det, overrun_err, busy;
    logic       data_valid_o, parity_err_o, framing_err_o, break_det_o, overrun_err_o, busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_cnt  = 0;
    int ovr_base = 0;

    uart_rx_param u_dut (
        .clk(clk), .reset(reset), .Rx_EN(Rx_EN), .RX_sample_ENABLE(RX_sample_ENABLE),
        .RxD(RxD), .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .parity_err(parity_err), .framing_err(framing_err), .break_det(break_det),
        .overrun_err(overrun_err), .busy(busy)
    );

    uart_rx_param #(.PARITY_ODD(1)) u_odd (
        .clk(clk), .reset(reset), .Rx_EN(Rx_EN), .RX_sample_ENABLE(RX_sample_ENABLE),
        .RxD(RxD), .data_out(data_out_o), .data_valid(data_valid_o), .data_ready(data_ready),
        .parity_err(parity_err_o), .framing_err(framing_err_o), .break_det(break_det_o),
        .overrun_err(overrun_err_o), .busy(busy_o)
    );

    always #5 clk = ~clk;

    // Width of each overrun pulse is counted in clocks.
    always @(negedge clk) if (overrun_err) ovr_cnt <= ovr_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start, 8 data bits LSB first, parity, stop, then idle ones.
    function automatic logic [15:0] mk(input logic [7:0] d, input logic p, input logic s);
        return {5'b11111, s, p, d, 1'b0};
    endfunction

    // One sample tick carrying line value v; line settles 3 clks before the tick.
    task automatic tick_with(input logic v, input logic rdy);
        @(negedge clk);
        RxD = v;
        repeat (3) @(negedge clk);
        RX_sample_ENABLE = 1'b1;
        if (rdy) data_ready = 1'b1;
        @(negedge clk);
        RX_sample_ENABLE = 1'b0;
        data_ready = 1'b0;
    endtask

    // 16 ticks per bit; inv flips one tick, rdy raises data_ready on one tick.
    task automatic send(input logic [15:0] f, input int nticks, input int inv, input int rdy);
        logic v;
        for (int i = 0; i < nticks; i++) begin
            v = (i < 176) ? f[i / 16] : 1'b1;
            if (i == inv) v = ~v;
            tick_with(v, i == rdy);
        end
    endtask

    task automatic consume();
        @(negedge clk);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_flags", {29'h0, parity_err, framing_err, break_det}, 32'h0);
        check("rst_busy_ovr", {30'h0, busy, overrun_err}, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Clean 0xA5, even parity bit 0
        send(mk(8'hA5, 1'b0, 1'b1), 192, -1, -1);
        check("a5_data", 32'(data_out), 32'hA5);
        check("a5_valid", 32'(data_valid), 32'h1);
        check("a5_flags", {29'h0, parity_err, framing_err, break_det}, 32'h0);
        check("a5_busy", 32'(busy), 32'h0);
        consume();
        check("a5_cleared", 32'(data_valid), 32'h0);

        // Parity bit 1: wrong for even, right for odd
        send(mk(8'hA5, 1'b1, 1'b1), 192, -1, -1);
        check("par_data", 32'(data_out), 32'hA5);
        check("par_flags", {29'h0, parity_err, framing_err, break_det}, 32'h4);
        check("par_odd_data", 32'(data_out_o), 32'hA5);
        check("par_odd_flags", {29'h0, parity_err_o, framing_err_o, break_det_o}, 32'h0);
        consume();

        // False start: 4 low ticks then high
        for (int i = 0; i < 4; i++) tick_with(1'b0, 1'b0);
        check("fs_busy_mid", 32'(busy), 32'h1);
        for (int i = 0; i < 12; i++) tick_with(1'b1, 1'b0);
        check("fs_busy_end", 32'(busy), 32'h0);
        check("fs_valid", 32'(data_valid), 32'h0);

        // 0x3C with one inverted tick at scnt = M of data bit 2
        send(mk(8'h3C, 1'b0, 1'b1), 192, 57, -1);
        check("glitch_data", 32'(data_out), 32'h3C);
        check("glitch_flags", {29'h0, parity_err, framing_err, break_det}, 32'h0);
        consume();

        // Stop bit low
        send(mk(8'h81, 1'b0, 1'b0), 192, -1, -1);
        check("frm_data", 32'(data_out), 32'h81);
        check("frm_flags", {29'h0, parity_err, framing_err, break_det}, 32'h2);
        consume();

        // Break: everything low
        send(mk(8'h00, 1'b0, 1'b0), 192, -1, -1);
        check("brk_data", 32'(data_out), 32'h00);
        check("brk_valid", 32'(data_valid), 32'h1);
        check("brk_flags", {29'h0, parity_err, framing_err, break_det}, 32'h3);
        consume();

        // Overrun: second frame dropped while 0x11 is held
        ovr_base = ovr_cnt;
        send(mk(8'h11, 1'b0, 1'b1), 192, -1, -1);
        send(mk(8'h22, 1'b0, 1'b1), 192, -1, -1);
        check("ovr_data", 32'(data_out), 32'h11);
        check("ovr_valid", 32'(data_valid), 32'h1);
        check("ovr_pulses", 32'(ovr_cnt - ovr_base), 32'h1);

        // Handshake on the completion tick lets the new word in
        ovr_base = ovr_cnt;
        send(mk(8'h22, 1'b0, 1'b1), 192, -1, 170);
        check("hs_data", 32'(data_out), 32'h22);
        check("hs_valid", 32'(data_valid), 32'h1);
        check("hs_no_ovr", 32'(ovr_cnt - ovr_base), 32'h0);
        consume();

        // Reset in the middle of the data bits with a word held
        send(mk(8'h5A, 1'b0, 1'b1), 192, -1, -1);
        send(mk(8'hFF, 1'b0, 1'b1), 40, -1, -1);
        check("mid_busy", 32'(busy), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_data", 32'(data_out), 32'h0);
        check("mid_rst_valid", 32'(data_valid), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) tick_with(1'b1, 1'b0);
        check("post_rst_valid", 32'(data_valid), 32'h0);
        check("post_rst_busy", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
